// File: rtl/sysid_check_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sysid_check_pkg : shared states, error codes and sysid word addresses |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package sysid_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_WT_ID = 3'd2,
        ST_RD_TS = 3'd3,
        ST_WT_TS = 3'd4,
        ST_CHECK = 3'd5,
        ST_PASS  = 3'd6,
        ST_FAIL  = 3'd7
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ID      = 2'd1;
    localparam logic [1:0] ERR_TS      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sysid_check_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sysid_check_ctrl_if : Avalon-MM read-only link to the sysid slave     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface sysid_check_ctrl_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (output avm_address, output avm_read,
                    input  avm_readdata, input avm_waitrequest);
    modport slave  (input  avm_address, input avm_read,
                    output avm_readdata, output avm_waitrequest);
endinterface
`default_nettype wire

// File: rtl/sysid_rd_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sysid_rd_timer : shared waitrequest timeout / read-latency counter    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module sysid_rd_timer #(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic clock,
    input  wire logic reset_n,
    input  wire logic stall,
    input  wire logic accept,
    input  wire logic waiting,
    output logic      timeout,
    output logic      expire
);

    localparam logic [15:0] C_LAT      = 16'(READ_LATENCY);
    localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    // Counts up while stalled, is loaded with the latency on acceptance and
    // counts down while waiting for data; idle otherwise.
    always_comb begin
        cnt_d = '0;
        if (stall)
            cnt_d = cnt_q + 16'd1;
        else if (accept)
            cnt_d = C_LAT;
        else if (waiting && (cnt_q != 16'd0))
            cnt_d = cnt_q - 16'd1;
    end

    assign timeout = stall && (cnt_q == C_TMO_LAST);
    assign expire  = waiting && (cnt_q == 16'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule
`default_nettype wire

// File: rtl/sysid_check_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sysid_check_ctrl : boot-time sysid ID/timestamp checker with retries  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1418711392,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    input  wire logic          start,
    sysid_check_ctrl_if.master avm,
    output logic               busy,
    output logic               sys_ok,
    output logic               sys_fail,
    output logic [1:0]         err_code,
    output logic [31:0]        id_value,
    output logic [31:0]        ts_value,
    output logic [3:0]         retry_count
);

    localparam logic [3:0] C_MAX_RETRY = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic [3:0]  retry_q, retry_d;
    logic [1:0]  err_q, err_d, err_now;
    logic [31:0] id_q, id_d, ts_q, ts_d;
    logic        tmo_q, tmo_d, auto_q, auto_d;
    logic        rd_req, rd_addr, launch, accept, stall, waiting, timeout, expire;

    assign accept  = rd_req && !avm.avm_waitrequest;
    assign stall   = rd_req &&  avm.avm_waitrequest;
    assign waiting = (state_q == ST_WT_ID) || (state_q == ST_WT_TS);

    sysid_rd_timer #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .stall   (stall),
        .accept  (accept),
        .waiting (waiting),
        .timeout (timeout),
        .expire  (expire)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        err_d   = err_q;
        id_d    = id_q;
        ts_d    = ts_q;
        tmo_d   = tmo_q;
        auto_d  = auto_q;
        rd_req  = 1'b0;
        rd_addr = SYSID_ADDR_ID;
        launch  = 1'b0;
        err_now = ERR_NONE;
        case (state_q)
            ST_IDLE: launch = start || (AUTO_START && !auto_q);
            ST_PASS, ST_FAIL: launch = start;
            ST_RD_ID: begin
                rd_req = 1'b1;
                if (timeout) begin
                    tmo_d   = 1'b1;
                    state_d = ST_CHECK;
                end else if (accept) begin
                    if (READ_LATENCY == 0) begin
                        id_d    = avm.avm_readdata;
                        state_d = ST_RD_TS;
                    end else begin
                        state_d = ST_WT_ID;
                    end
                end
            end
            ST_WT_ID: if (expire) begin
                id_d    = avm.avm_readdata;
                state_d = ST_RD_TS;
            end
            ST_RD_TS: begin
                rd_req  = 1'b1;
                rd_addr = SYSID_ADDR_TS;
                if (timeout) begin
                    tmo_d   = 1'b1;
                    state_d = ST_CHECK;
                end else if (accept) begin
                    if (READ_LATENCY == 0) begin
                        ts_d    = avm.avm_readdata;
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_WT_TS;
                    end
                end
            end
            ST_WT_TS: if (expire) begin
                ts_d    = avm.avm_readdata;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // A timed-out attempt may leave stale captures, so it wins.
                if (tmo_q)                   err_now = ERR_TIMEOUT;
                else if (id_q != EXPECTED_ID) err_now = ERR_ID;
                else if (ts_q != EXPECTED_TS) err_now = ERR_TS;
                err_d = err_now;
                if (err_now == ERR_NONE) begin
                    state_d = ST_PASS;
                end else if (retry_q < C_MAX_RETRY) begin
                    retry_d = retry_q + 4'd1;
                    tmo_d   = 1'b0;
                    state_d = ST_RD_ID;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (launch) begin
            state_d = ST_RD_ID;
            retry_d = '0;
            err_d   = ERR_NONE;
            tmo_d   = 1'b0;
            auto_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            retry_q <= '0;
            err_q   <= ERR_NONE;
            id_q    <= '0;
            ts_q    <= '0;
            tmo_q   <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            err_q   <= err_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            tmo_q   <= tmo_d;
            auto_q  <= auto_d;
        end
    end

    assign avm.avm_read    = rd_req;
    assign avm.avm_address = rd_addr;
    assign busy        = !((state_q == ST_IDLE) || (state_q == ST_PASS) || (state_q == ST_FAIL));
    assign sys_ok      = (state_q == ST_PASS);
    assign sys_fail    = (state_q == ST_FAIL);
    assign err_code    = err_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
    assign retry_count = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_sysid_check_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sysid_check_ctrl : scoreboard bench over three parameterisations   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_sysid_check_ctrl;

    localparam logic [31:0] C_TS_OK  = 32'd1418711392;
    localparam logic [31:0] C_TS_BAD = 32'd1418711393;
    localparam int          C_BUDGET = 2000;

    typedef struct {
        int          dut;
        logic        ok;
        logic        fail;
        logic [1:0]  err;
        logic [3:0]  rc;
        logic [31:0] id;
        logic [31:0] ts;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start_a = 1'b0;
    logic start_idle = 1'b0;
    logic stall_ts_a = 1'b0;
    logic [31:0] ts_a = C_TS_OK;

    logic [2:0]  busy, ok, fail;
    logic [1:0]  err [3];
    logic [31:0] idv [3];
    logic [31:0] tsv [3];
    logic [3:0]  rc  [3];

    always #5 clock = ~clock;

    sysid_check_ctrl_if ifa ();
    sysid_check_ctrl_if ifb ();
    sysid_check_ctrl_if ifc ();

    // A: stock config with a combinational slave.
    assign ifa.avm_waitrequest = stall_ts_a && ifa.avm_address;
    assign ifa.avm_readdata    = ifa.avm_address ? ts_a : 32'h0;
    // B: slave that never accepts.
    assign ifb.avm_waitrequest = 1'b1;
    assign ifb.avm_readdata    = 32'h0BAD_0BAD;

    // C: two-cycle latency slave; data is only valid in the exact cycle.
    logic p1v = 1'b0, p2v = 1'b0, p1a = 1'b0, p2a = 1'b0;
    int   idrd_c = 0;
    assign ifc.avm_waitrequest = 1'b0;
    assign ifc.avm_readdata = !p2v ? 32'hDEAD_BEEF :
                              p2a  ? C_TS_OK : ((idrd_c == 1) ? 32'h1 : 32'h0);
    always @(posedge clock) begin
        p1v <= ifc.avm_read;
        p1a <= ifc.avm_address;
        p2v <= p1v;
        p2a <= p1a;
        if (ifc.avm_read && !ifc.avm_address) idrd_c <= idrd_c + 1;
    end

    sysid_check_ctrl u_dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .avm(ifa.master),
        .busy(busy[0]), .sys_ok(ok[0]), .sys_fail(fail[0]), .err_code(err[0]),
        .id_value(idv[0]), .ts_value(tsv[0]), .retry_count(rc[0]));

    sysid_check_ctrl #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(0)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_idle), .avm(ifb.master),
        .busy(busy[1]), .sys_ok(ok[1]), .sys_fail(fail[1]), .err_code(err[1]),
        .id_value(idv[1]), .ts_value(tsv[1]), .retry_count(rc[1]));

    sysid_check_ctrl #(.READ_LATENCY(2)) u_dut_c (
        .clock(clock), .reset_n(reset_n), .start(start_idle), .avm(ifc.master),
        .busy(busy[2]), .sys_ok(ok[2]), .sys_fail(fail[2]), .err_code(err[2]),
        .id_value(idv[2]), .ts_value(tsv[2]), .retry_count(rc[2]));

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Address order and read counts on A; stalled-read tracking on B.
    logic exp_addr_a = 1'b0;
    int   idrd_a = 0, tsrd_a = 0, rdhi_b = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_addr_a <= 1'b0;
        end else begin
            if (ifa.avm_read && !ifa.avm_waitrequest) begin
                chk_eq("a_addr_order", 32'(ifa.avm_address), 32'(exp_addr_a));
                exp_addr_a <= ~ifa.avm_address;
                if (ifa.avm_address) tsrd_a <= tsrd_a + 1;
                else                 idrd_a <= idrd_a + 1;
            end
            if (ifb.avm_read) begin
                chk_eq("b_addr_stable", 32'(ifb.avm_address), 32'h0);
                rdhi_b <= rdhi_b + 1;
            end
        end
    end

    task automatic push_exp(input int d, input logic o, input logic f, input logic [1:0] e,
                            input logic [3:0] r, input logic [31:0] i, input logic [31:0] t);
        exp_t x;
        x.dut = d; x.ok = o; x.fail = f; x.err = e; x.rc = r; x.id = i; x.ts = t;
        sb_q.push_back(x);
    endtask

    task automatic wait_done(output int cycles);
        exp_t x;
        string n;
        x = sb_q.pop_front();
        n = $sformatf("dut%0d", x.dut);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!(!busy[x.dut] && (ok[x.dut] || fail[x.dut])) && cycles < C_BUDGET);
        chk_eq({n, "_done_in_budget"}, 32'(cycles < C_BUDGET), 32'h1);
        chk_eq({n, "_sys_ok"},   32'(ok[x.dut]),   32'(x.ok));
        chk_eq({n, "_sys_fail"}, 32'(fail[x.dut]), 32'(x.fail));
        chk_eq({n, "_err_code"}, 32'(err[x.dut]),  32'(x.err));
        chk_eq({n, "_retry"},    32'(rc[x.dut]),   32'(x.rc));
        chk_eq({n, "_id_value"}, idv[x.dut],       x.id);
        chk_eq({n, "_ts_value"}, tsv[x.dut],       x.ts);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
    endtask

    initial begin
        int cyc, id0, ts0;
        repeat (2) @(negedge clock);
        chk_eq("rst_busy", 32'(busy), 32'h0);
        chk_eq("rst_ok_fail", 32'({ok, fail}), 32'h0);
        chk_eq("rst_read", 32'({ifa.avm_read, ifb.avm_read, ifc.avm_read}), 32'h0);
        chk_eq("rst_err_rc", 32'({err[0], rc[0], idv[0] | tsv[0]}), 32'h0);

        // Auto-start on all three after release.
        push_exp(0, 1, 0, 2'd0, 4'd0, 32'h0, C_TS_OK);
        push_exp(1, 0, 1, 2'd3, 4'd0, 32'h0, 32'h0);
        push_exp(2, 1, 0, 2'd0, 4'd1, 32'h0, C_TS_OK);
        reset_n = 1'b1;
        wait_done(cyc);
        chk_eq("a_latency_cycles", 32'(cyc), 32'd4);
        wait_done(cyc);
        chk_eq("b_read_high_cycles", 32'(rdhi_b), 32'd4);
        wait_done(cyc);

        // Timestamp mismatch on every attempt; a start while busy is ignored.
        ts_a = C_TS_BAD;
        id0 = idrd_a; ts0 = tsrd_a;
        push_exp(0, 0, 1, 2'd2, 4'd3, 32'h0, C_TS_BAD);
        pulse_start_a();
        repeat (3) @(negedge clock);
        pulse_start_a();
        wait_done(cyc);
        chk_eq("a_id_reads", 32'(idrd_a - id0), 32'd4);
        chk_eq("a_ts_reads", 32'(tsrd_a - ts0), 32'd4);

        // Rerun from FAIL, then from PASS.
        ts_a = C_TS_OK;
        push_exp(0, 1, 0, 2'd0, 4'd0, 32'h0, C_TS_OK);
        pulse_start_a();
        wait_done(cyc);
        push_exp(0, 1, 0, 2'd0, 4'd0, 32'h0, C_TS_OK);
        pulse_start_a();
        chk_eq("a_rerun_clears_ok", 32'(ok[0]), 32'h0);
        chk_eq("a_rerun_busy", 32'(busy[0]), 32'h1);
        wait_done(cyc);

        // Asynchronous reset while the timestamp read is stalled.
        stall_ts_a = 1'b1;
        pulse_start_a();
        for (int i = 0; i < 20 && !(ifa.avm_read && ifa.avm_address); i++) @(negedge clock);
        chk_eq("a_in_rd_ts", 32'(ifa.avm_read && ifa.avm_address), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("arst_read", 32'(ifa.avm_read), 32'h0);
        chk_eq("arst_busy", 32'(busy[0]), 32'h0);
        chk_eq("arst_ts_value", tsv[0], 32'h0);
        chk_eq("arst_err_rc", 32'({err[0], rc[0], ok[0], fail[0]}), 32'h0);
        stall_ts_a = 1'b0;
        @(negedge clock);
        @(negedge clock);
        push_exp(0, 1, 0, 2'd0, 4'd0, 32'h0, C_TS_OK);
        reset_n = 1'b1;
        wait_done(cyc);
        chk_eq("a_latency_after_rst", 32'(cyc), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
